// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } mdu_state_e;

    typedef enum logic {
        MODE_MUL,
        MODE_DIV
    } mdu_mode_e;

    localparam logic [31:0] DIV0_Q    = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;
    localparam logic [4:0]  ITER_LAST = 5'd31;

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step on a 64-bit accumulator.
module mdu_iter_step
    import mdu_pkg::*;
(
    input  mdu_mode_e   mode,
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    output logic [63:0] acc_next
);

    logic [32:0] sum;
    logic [31:0] diff;
    logic        fits;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {remainder, dividend/quotient bits}.
    // NOTE: every output gets a default first, so no path through this block infers a latch.
    always_comb begin
        acc_next = '0;
        sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
        fits     = acc[63:31] >= {1'b0, operand};
        diff     = acc[62:31] - operand;
        if (mode == MODE_MUL) begin
            acc_next = {sum, acc[31:1]};
        end else if (fits) begin
            acc_next = {diff, acc[30:0], 1'b1};
        end else begin
            acc_next = {acc[62:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_seq_ctrl.sv
// Multi-cycle RV32M MUL/DIV/REM sequencer: iterative radix-2 datapath with sign fix-up,
// valid/ready handshakes on both sides, fast paths for divide-by-zero and signed overflow.
module mdu_seq_ctrl
    import mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    mdu_state_e        state_q, state_d;
    logic [4:0]        cnt_q;
    logic [TAG_W-1:0]  tag_q;
    logic [XLEN-1:0]   result_q;

    logic [2*XLEN-1:0] acc_q, acc_next;
    logic [XLEN-1:0]   opnd_q;
    mdu_op_e           op_q;
    logic              neg_q, rem_neg_q;

    mdu_op_e           op_in;
    logic              accept, is_div_in, a_signed, b_signed, a_neg, b_neg;
    logic              div_zero, div_ovf, fast;
    logic [XLEN-1:0]   mag_a, mag_b, fast_result, fix_result;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem;

    assign in_ready   = (state_q == IDLE) && !flush;
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign out_result = result_q;
    assign out_tag    = tag_q;

    // Request decode, sign handling and fast-path detection, all resolved at accept.
    always_comb begin
        op_in     = mdu_op_e'(in_op);
        is_div_in = in_op[2];
        a_signed  = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_signed  = op_in inside {OP_MULH, OP_DIV, OP_REM};
        a_neg     = a_signed && in_a[XLEN-1];
        b_neg     = b_signed && in_b[XLEN-1];
        mag_a     = a_neg ? -in_a : in_a;
        mag_b     = b_neg ? -in_b : in_b;
        div_zero  = is_div_in && (in_b == '0);
        div_ovf   = (op_in inside {OP_DIV, OP_REM}) && (in_a == INT_MIN) && (in_b == '1);
        fast      = div_zero || div_ovf;
        if (div_zero) begin
            fast_result = (op_in inside {OP_DIV, OP_DIVU}) ? DIV0_Q : in_a;
        end else begin
            fast_result = (op_in == OP_DIV) ? INT_MIN : '0;
        end
    end

    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        quot = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = rem_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                         fix_result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   fix_result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:                fix_result = quot;
            default:                        fix_result = rem;
        endcase
    end

    mdu_iter_step u_step (
        .mode     (mdu_mode_e'(op_q[2])),
        .acc      (acc_q),
        .operand  (opnd_q),
        .acc_next (acc_next)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = fast ? DONE : CALC;
            CALC: if (cnt_q == ITER_LAST) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tag_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (flush || state_q != CALC) ? 5'd0 : cnt_q + 5'd1;
            if (accept) begin
                tag_q <= in_tag;
                if (fast) result_q <= fast_result;
            end
            if (state_q == FIX && !flush) result_q <= fix_result;
        end
    end

    // NOTE: datapath registers are always loaded at accept before being read, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q      <= op_in;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= is_div_in && a_neg;
            opnd_q    <= is_div_in ? mag_b : mag_a;
            acc_q     <= {{XLEN{1'b0}}, (is_div_in ? mag_a : mag_b)};
        end else if (state_q == CALC) begin
            acc_q <= acc_next;
        end
    end

endmodule
